// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words onto a ccff chain head,
// gates the chain clock, and collects the bits leaving the tail into readback words.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 36,
   parameter int DATA_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ccff_head,
   output logic              ccff_clk_en,
   input  logic              ccff_tail,
   output logic [DATA_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              busy,
   output logic              done
);

   localparam int SW = $clog2(CHAIN_LEN + 1);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SHIFT   = 3'd1;
   localparam logic [2:0] S_FLUSH   = 3'd2;
   localparam logic [2:0] S_WAIT_RB = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [SW-1:0] LAST_SCNT = SW'(CHAIN_LEN - 1);
   localparam logic [BW-1:0] FULL_CNT  = BW'(DATA_W - 1);
   localparam logic [BW-1:0] WORD_BITS = BW'(DATA_W);
   localparam logic [BW-1:0] ONE_BIT   = BW'(1);

   logic [2:0]        r_state;
   logic [DATA_W-1:0] r_sreg;
   logic [BW-1:0]     r_bits_left;
   logic [SW-1:0]     r_scnt;
   logic [DATA_W-1:0] r_coll;
   logic [BW-1:0]     r_coll_cnt;
   logic [DATA_W-1:0] r_rb_data;
   logic              r_rb_valid;

   logic              w_out_free;
   logic              w_shift;
   logic              w_last;
   logic              w_coll_full;
   logic              w_in_ready;
   logic              w_accept;
   logic [DATA_W-1:0] w_coll_next;

   always_comb begin
      w_out_free  = !r_rb_valid || rb_ready;
      // Hold the chain only when the capture would overflow a collector that cannot drain.
      w_shift     = (r_state == S_SHIFT) && (r_bits_left != '0) &&
                    !((r_coll_cnt == FULL_CNT) && r_rb_valid && !rb_ready);
      w_last      = w_shift && (r_scnt == LAST_SCNT);
      w_coll_full = w_shift && (r_coll_cnt == FULL_CNT);
      w_in_ready  = (r_state == S_SHIFT) && !w_last &&
                    ((r_bits_left == '0) || ((r_bits_left == ONE_BIT) && w_shift));
      w_accept    = in_valid && w_in_ready;
   end

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_coll
         assign w_coll_next[gi] = (w_shift && (r_coll_cnt == BW'(gi))) ? ccff_tail : r_coll[gi];
      end
   endgenerate

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         r_state     <= S_IDLE;
         r_sreg      <= '0;
         r_bits_left <= '0;
         r_scnt      <= '0;
         r_coll      <= '0;
         r_coll_cnt  <= '0;
         r_rb_data   <= '0;
         r_rb_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:    if (start) r_state <= S_SHIFT;
            S_SHIFT:   if (w_last) r_state <= w_coll_full ? S_WAIT_RB : S_FLUSH;
            S_FLUSH:   if (w_out_free) r_state <= S_WAIT_RB;
            S_WAIT_RB: if (!r_rb_valid) r_state <= S_DONE;
            S_DONE:    r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase

         // Leftover bits of the final word are dropped once the chain is full.
         if (w_last) begin
            r_sreg      <= '0;
            r_bits_left <= '0;
         end else if (w_accept) begin
            r_sreg      <= in_data;
            r_bits_left <= WORD_BITS;
         end else if (w_shift) begin
            r_sreg      <= {1'b0, r_sreg[DATA_W-1:1]};
            r_bits_left <= r_bits_left - ONE_BIT;
         end

         if ((r_state == S_IDLE) && start) r_scnt <= '0;
         else if (w_shift)                 r_scnt <= r_scnt + SW'(1);

         if (w_coll_full) begin
            r_rb_data  <= w_coll_next;
            r_rb_valid <= 1'b1;
            r_coll     <= '0;
            r_coll_cnt <= '0;
         end else if ((r_state == S_FLUSH) && w_out_free) begin
            r_rb_data  <= r_coll;
            r_rb_valid <= 1'b1;
            r_coll     <= '0;
            r_coll_cnt <= '0;
         end else begin
            r_coll <= w_coll_next;
            if (w_shift) r_coll_cnt <= r_coll_cnt + ONE_BIT;
            if (r_rb_valid && rb_ready) r_rb_valid <= 1'b0;
         end
      end
   end

   assign in_ready    = w_in_ready;
   assign ccff_clk_en = w_shift;
   assign ccff_head   = r_sreg[0];
   assign rb_data     = r_rb_data;
   assign rb_valid    = r_rb_valid;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a behavioural chain model plus head-bit and readback
// scoreboards filled when each load is launched and drained as the DUT shifts.
module tb_ccff_chain_loader;
   localparam int CHAIN_LEN = 36;
   localparam int DATA_W    = 8;
   localparam int NW        = 5;
   localparam int NRB       = (CHAIN_LEN + DATA_W - 1) / DATA_W;

   logic              clk = 1'b0;
   logic              prog_reset;
   logic              start;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ccff_head;
   logic              ccff_clk_en;
   logic              ccff_tail;
   logic [DATA_W-1:0] rb_data;
   logic              rb_valid;
   logic              rb_ready;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
      .prog_clk(clk), .prog_reset(prog_reset), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
      .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
      .busy(busy), .done(done)
   );

   // Behavioural configuration chain clocked through the ICG enable.
   logic [CHAIN_LEN-1:0] chain;
   logic [CHAIN_LEN-1:0] chain_init;
   logic                 chain_load;
   assign ccff_tail = chain[CHAIN_LEN-1];
   always @(posedge clk) begin
      if (chain_load)       chain <= chain_init;
      else if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
   end

   logic [DATA_W-1:0] words [NW];
   logic              hq  [$];
   logic [DATA_W-1:0] rbq [$];
   int                shift_cnt = 0;
   int                n_checks  = 0;
   int                n_errors  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ccff_clk_en) begin
         shift_cnt++;
         if (hq.size() == 0) check("head_extra_shift", 32'd1, 32'd0);
         else                check("head_bit", {31'd0, ccff_head}, {31'd0, hq.pop_front()});
      end
      if (rb_valid && rb_ready) begin
         if (rbq.size() == 0) check("rb_extra_word", {24'd0, rb_data}, 32'hFFFF_FFFF);
         else                 check("rb_word", {24'd0, rb_data}, {24'd0, rbq.pop_front()});
      end
   end

   task automatic run_load(input string name, input bit rb_from_words,
                           input int gap_lo, input int gap_hi,
                           input int stall_lo, input int stall_hi,
                           input int rst_at, input int ign_start_at,
                           input int exp_first, input int exp_last);
      int cyc, widx, base, first_en, last_en, n_en, n_done;
      bit acc, seen_done, finished, aborted;
      logic [DATA_W-1:0] wd;
      cyc = 0; widx = 0; first_en = -1; last_en = -1; n_en = 0; n_done = 0;
      seen_done = 0; finished = 0; aborted = 0;
      @(posedge clk); #1;
      hq.delete();
      rbq.delete();
      for (int k = 0; k < CHAIN_LEN; k++) hq.push_back(words[k / DATA_W][k % DATA_W]);
      for (int w = 0; w < NRB; w++) begin
         wd = '0;
         for (int b = 0; b < DATA_W; b++) begin
            if (w * DATA_W + b < CHAIN_LEN)
               wd[b] = rb_from_words ? words[w][b] : chain[CHAIN_LEN - 1 - (w * DATA_W + b)];
         end
         rbq.push_back(wd);
      end
      base     = shift_cnt;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = words[0];
      rb_ready = 1'b1;
      for (int guard = 0; guard < 400; guard++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (ccff_clk_en) begin
            if (n_en == 0) first_en = cyc;
            last_en = cyc;
            n_en++;
         end
         if (stall_lo >= 0 && cyc == 25) begin
            check("stall_shift_count", shift_cnt - base, 32'd15);
            check("stall_rb_pending", {31'd0, rb_valid}, 32'd1);
            check("stall_clk_en", {31'd0, ccff_clk_en}, 32'd0);
         end
         if (rst_at >= 0 && cyc == rst_at + 1) begin
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_clk_en", {31'd0, ccff_clk_en}, 32'd0);
            check("rst_rb_valid", {31'd0, rb_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_head", {31'd0, ccff_head}, 32'd0);
            aborted = 1;
            break;
         end
         if (seen_done) begin
            check("busy_after_done", {31'd0, busy}, 32'd0);
            finished = 1;
            break;
         end
         if (done) begin
            n_done++;
            seen_done = 1;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) widx++;
         start      = (cyc == ign_start_at);
         prog_reset = (cyc == rst_at);
         in_valid   = (widx < NW) && !(cyc >= gap_lo && cyc <= gap_hi);
         in_data    = (widx < NW) ? words[widx] : '0;
         rb_ready   = !(cyc >= stall_lo && cyc <= stall_hi);
      end
      if (aborted) begin
         hq.delete();
         rbq.delete();
         in_valid = 1'b0;
         start    = 1'b0;
      end else if (!finished) begin
         check("load_timeout", 32'd0, 32'd1);
      end else begin
         check("done_pulses", n_done, 32'd1);
         check("shift_total", n_en, CHAIN_LEN);
         check("first_clk_en", first_en, exp_first);
         check("last_clk_en", last_en, exp_last);
         check("head_left", hq.size(), 32'd0);
         check("rb_left", rbq.size(), 32'd0);
      end
      $display("load %s: shifts=%0d first_en=%0d last_en=%0d done=%0d aborted=%0d",
               name, n_en, first_en, last_en, n_done, aborted);
   endtask

   initial begin
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h0F;
      prog_reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rb_ready = 1'b1;
      chain_init = {4'($urandom()), $urandom()};
      chain_load = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      prog_reset = 1'b0;
      chain_load = 1'b0;
      @(negedge clk);
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      check("reset_clk_en", {31'd0, ccff_clk_en}, 32'd0);
      check("reset_head", {31'd0, ccff_head}, 32'd0);
      check("reset_rb_valid", {31'd0, rb_valid}, 32'd0);
      check("reset_rb_data", {24'd0, rb_data}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);

      run_load("base",   1'b0, -1, -1, -1, -1, -1, -1, 2, 37);
      run_load("reload", 1'b1, -1, -1, -1, -1, -1, -1, 2, 37);
      run_load("gap",    1'b1, 17, 19, -1, -1, -1, -1, 2, 40);
      run_load("stall",  1'b1, -1, -1, 5, 30, -1, -1, 2, 51);
      run_load("reset",  1'b1, -1, -1, -1, -1, 20, -1, 0, 0);
      run_load("after_reset", 1'b0, -1, -1, -1, -1, -1, -1, 2, 37);

      // in_valid while idle must not be accepted or start anything.
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_in_ready", {31'd0, in_ready}, 32'd0);
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_clk_en", {31'd0, ccff_clk_en}, 32'd0);
      end
      run_load("start_ignored", 1'b1, -1, -1, -1, -1, -1, 12, 2, 37);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
